simd_cs_resolve: RTL and testbench

- Downstream consumer of the SIMD multiply-AND unit's redundant output pair (ps/sc). Collapses each beat into final per-lane results.
- Arithmetic mode: per-lane modular addition ps+sc, with carries cut at lane boundaries.
- Boolean mode: bitwise XOR ps^sc.
- Four-stage 64-bit-slice carry pipeline with valid/ready flow control and bubble collapsing. Sits between simd_muland and the correlated-randomness output FIFO.

---
 rtl/simd_cs_resolve.sv | 158 +++++++++++++++
 tb/tb_simd_cs_resolve.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_cs_resolve.sv
// Collapses a redundant ps/sc beat into final per-lane results: lane-modular
// addition (arithmetic mode) or XOR (boolean mode), one 64-bit slice per stage.
module simd_cs_resolve #(
  parameter int unsigned W     = 256,
  parameter int unsigned SLICE = 64
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] ps_i,
  input  logic [W-1:0] sc_i,
  input  logic [2:0]   mode_i,
  input  logic [2:0]   width_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] res_o,
  output logic [2:0]   mode_o,
  output logic [2:0]   width_o
);

  localparam int unsigned NS = W / SLICE;
  localparam int unsigned CH = 32;

  // Resolves slice k; the carry into each 32-bit chunk is killed when the
  // chunk start is a lane start for the beat's width code.
  function automatic logic [SLICE:0] resolve(
    input int unsigned      k,
    input logic [SLICE-1:0] a,
    input logic [SLICE-1:0] b,
    input logic             cin,
    input logic             arith,
    input logic [2:0]       wc
  );
    logic [SLICE-1:0] r;
    logic [CH:0]      s;
    logic             c;
    int unsigned      lane_bits;
    int unsigned      pos;
    case (wc)
      3'b001:  lane_bits = 64;
      3'b011:  lane_bits = 128;
      3'b111:  lane_bits = 256;
      default: lane_bits = 32;
    endcase
    r = '0;
    c = cin;
    for (int unsigned j = 0; j < SLICE / CH; j++) begin
      pos = k * SLICE + j * CH;
      if ((pos & (lane_bits - 1)) == 0) c = 1'b0;
      s = {1'b0, a[j*CH +: CH]} + {1'b0, b[j*CH +: CH]} + {{CH{1'b0}}, c};
      r[j*CH +: CH] = s[CH-1:0];
      c = s[CH];
    end
    if (!arith) begin
      r = a ^ b;
      c = 1'b0;
    end
    return {c, r};
  endfunction

  logic [NS-1:0] vld_q, vld_d;
  logic [NS-1:0] adv;
  logic [W-1:0]  res_q   [NS];
  logic [W-1:0]  res_d   [NS];
  logic [W-1:0]  sc_q    [NS];
  logic [W-1:0]  sc_d    [NS];
  logic          cy_q    [NS];
  logic          cy_d    [NS];
  logic [2:0]    mode_q  [NS];
  logic [2:0]    mode_d  [NS];
  logic [2:0]    width_q [NS];
  logic [2:0]    width_d [NS];

  // A stage may load when any stage at or after it is empty, or the output drains.
  always_comb begin
    adv = '0;
    for (int unsigned k = 0; k < NS; k++) begin
      adv[k] = ready_i;
      for (int unsigned j = k; j < NS; j++) begin
        if (!vld_q[j]) adv[k] = 1'b1;
      end
    end
  end

  always_comb begin : stage_next
    logic [W-1:0]   src_res;
    logic [W-1:0]   src_sc;
    logic           src_vld;
    logic           src_cy;
    logic [2:0]     src_mode;
    logic [2:0]     src_width;
    logic [SLICE:0] rs;
    vld_d = vld_q;
    for (int unsigned k = 0; k < NS; k++) begin
      res_d[k]   = res_q[k];
      sc_d[k]    = sc_q[k];
      cy_d[k]    = cy_q[k];
      mode_d[k]  = mode_q[k];
      width_d[k] = width_q[k];
      if (k == 0) begin
        src_vld   = valid_i;
        src_res   = ps_i;
        src_sc    = sc_i;
        src_cy    = 1'b0;
        src_mode  = mode_i;
        src_width = width_i;
      end else begin
        src_vld   = vld_q[k-1];
        src_res   = res_q[k-1];
        src_sc    = sc_q[k-1];
        src_cy    = cy_q[k-1];
        src_mode  = mode_q[k-1];
        src_width = width_q[k-1];
      end
      rs = resolve(k, src_res[k*SLICE +: SLICE], src_sc[k*SLICE +: SLICE],
                   src_cy, src_mode[2], src_width);
      if (adv[k]) begin
        vld_d[k] = src_vld;
        if (src_vld) begin
          res_d[k]                 = src_res;
          res_d[k][k*SLICE +: SLICE] = rs[SLICE-1:0];
          sc_d[k]                  = src_sc;
          cy_d[k]                  = rs[SLICE];
          mode_d[k]                = src_mode;
          width_d[k]               = src_width;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_q <= '0;
      for (int unsigned k = 0; k < NS; k++) begin
        res_q[k]   <= '0;
        sc_q[k]    <= '0;
        cy_q[k]    <= 1'b0;
        mode_q[k]  <= '0;
        width_q[k] <= '0;
      end
    end else begin
      vld_q   <= vld_d;
      res_q   <= res_d;
      sc_q    <= sc_d;
      cy_q    <= cy_d;
      mode_q  <= mode_d;
      width_q <= width_d;
    end
  end

  assign ready_o = adv[0];
  assign valid_o = vld_q[NS-1];
  assign res_o   = res_q[NS-1];
  assign mode_o  = mode_q[NS-1];
  assign width_o = width_q[NS-1];

endmodule

// File: tb/tb_simd_cs_resolve.sv
// Self-checking bench for simd_cs_resolve: directed carry/lane cases plus a
// randomized stream scored against a lane-arithmetic reference model.
module tb_simd_cs_resolve;

  localparam int unsigned W = 256;

  logic         clk = 1'b0;
  logic         rst_n_i;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] ps_i;
  logic [W-1:0] sc_i;
  logic [2:0]   mode_i;
  logic [2:0]   width_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] res_o;
  logic [2:0]   mode_o;
  logic [2:0]   width_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [W-1:0] r;
    logic [2:0]   m;
    logic [2:0]   w;
  } exp_t;

  exp_t q[$];

  simd_cs_resolve #(.W(W), .SLICE(64)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .ps_i    (ps_i),
    .sc_i    (sc_i),
    .mode_i  (mode_i),
    .width_i (width_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .res_o   (res_o),
    .mode_o  (mode_o),
    .width_o (width_o)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [W-1:0] ps, input logic [W-1:0] sc,
                                         input logic [2:0] m, input logic [2:0] w);
    int unsigned  lb;
    logic [W-1:0] r, mask, a, b;
    if (!m[2]) return ps ^ sc;
    case (w)
      3'b001:  lb = 64;
      3'b011:  lb = 128;
      3'b111:  lb = 256;
      default: lb = 32;
    endcase
    mask = (lb == 256) ? '1 : ((256'd1 << lb) - 256'd1);
    r = '0;
    for (int unsigned off = 0; off < W; off += lb) begin
      a = (ps >> off) & mask;
      b = (sc >> off) & mask;
      r = r | (((a + b) & mask) << off);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [W-1:0] repl32(input logic [31:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = v;
    return r;
  endfunction

  // Sends one beat into an empty pipeline with ready_i high; reports acceptance,
  // cycles until valid_o, and the output seen.
  task automatic run_beat(input logic [W-1:0] p, input logic [W-1:0] s,
                          input logic [2:0] m, input logic [2:0] w,
                          output logic acc, output int unsigned lat,
                          output logic [W-1:0] r, output logic [2:0] mo, output logic [2:0] wo);
    @(negedge clk);
    ready_i = 1'b1;
    valid_i = 1'b1;
    ps_i = p; sc_i = s; mode_i = m; width_i = w;
    #1 acc = ready_o;
    @(negedge clk);
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r = res_o; mo = mode_o; wo = width_o;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    ps_i = '0; sc_i = '0; mode_i = '0; width_i = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || res_o !== '0 || mode_o !== 3'b0 || width_o !== 3'b0) begin
      errors++;
      $display("FAIL reset_outputs valid_o=%b mode_o=%b width_o=%b res_o=%h required 0", valid_o, mode_o, width_o, res_o);
    end
    rst_n_i = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready ready_o=%b required 1", ready_o);
    end
  endtask

  task automatic test_arith_w32();
    logic acc; int unsigned lat; logic [W-1:0] r; logic [2:0] mo, wo;
    run_beat(repl32(32'hFFFF_FFFF), repl32(32'h1), 3'b100, 3'b000, acc, lat, r, mo, wo);
    checks++;
    if (acc !== 1'b1 || lat != 4) begin
      errors++;
      $display("FAIL w32_latency accepted=%b latency=%0d required 1/4", acc, lat);
    end
    checks++;
    if (r !== '0 || mo !== 3'b100 || wo !== 3'b000) begin
      errors++;
      $display("FAIL w32_lanes res=%h mode=%b width=%b required 0/100/000", r, mo, wo);
    end
  endtask

  task automatic test_arith_w256();
    logic acc; int unsigned lat; logic [W-1:0] r, one, exp2; logic [2:0] mo, wo;
    one = 256'd1;
    run_beat('1, one, 3'b100, 3'b111, acc, lat, r, mo, wo);
    checks++;
    if (r !== '0 || lat != 4) begin
      errors++;
      $display("FAIL w256_wrap res=%h latency=%0d required 0/4", r, lat);
    end
    exp2 = 256'd1 << 64;
    run_beat((256'd1 << 64) - 256'd1, one, 3'b100, 3'b111, acc, lat, r, mo, wo);
    checks++;
    if (r !== exp2 || wo !== 3'b111) begin
      errors++;
      $display("FAIL w256_slice_carry res=%h width=%b required %h/111", r, wo, exp2);
    end
  endtask

  task automatic test_arith_w128();
    logic acc; int unsigned lat; logic [W-1:0] r, p, one, e; logic [2:0] mo, wo;
    logic [127:0] hi;
    one = 256'd1;
    hi = {$urandom, $urandom, $urandom, $urandom};
    p = {hi, {128{1'b1}}};
    e = {hi, 128'd0};
    run_beat(p, one, 3'b100, 3'b011, acc, lat, r, mo, wo);
    checks++;
    if (r !== e) begin
      errors++;
      $display("FAIL w128_lane_kill res=%h required %h", r, e);
    end
    e = 256'd1 << 64;
    run_beat((256'd1 << 64) - 256'd1, one, 3'b100, 3'b011, acc, lat, r, mo, wo);
    checks++;
    if (r !== e) begin
      errors++;
      $display("FAIL w128_slice_carry res=%h required %h", r, e);
    end
    p = {{64{1'b0}}, {64{1'b1}}, {128{1'b1}}};
    e = {{64{1'b0}}, {64{1'b1}}, 128'd0} + (256'd1 << 128) - (256'd1 << 128);
    run_beat(p, one, 3'b100, 3'b011, acc, lat, r, mo, wo);
    checks++;
    if (r !== e) begin
      errors++;
      $display("FAIL w128_no_cross_lane res=%h required %h", r, e);
    end
  endtask

  task automatic test_boolean();
    logic acc; int unsigned lat; logic [W-1:0] r; logic [2:0] mo, wo;
    logic [2:0] codes [4];
    codes[0] = 3'b000; codes[1] = 3'b001; codes[2] = 3'b011; codes[3] = 3'b111;
    for (int i = 0; i < 4; i++) begin
      run_beat(repl32(32'hA5A5_A5A5), '1, 3'b010, codes[i], acc, lat, r, mo, wo);
      checks++;
      if (r !== repl32(32'h5A5A_5A5A) || mo !== 3'b010 || lat != 4) begin
        errors++;
        $display("FAIL bool_w%0d res=%h mode=%b latency=%0d required 5a..5a/010/4", i, r, mo, lat);
      end
    end
  endtask

  task automatic test_mixed();
    int unsigned sent = 0, got = 0;
    logic [W-1:0] p, s;
    logic [2:0] m, w;
    exp_t e;
    q.delete();
    ready_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      valid_i = (sent < 8);
      p = rand_word(); s = rand_word();
      m = sent[0] ? 3'b010 : 3'b100;
      w = (sent % 3 == 0) ? 3'b111 : 3'b000;
      ps_i = p; sc_i = s; mode_i = m; width_i = w;
      #1;
      if (valid_o && ready_i) begin
        e = q.pop_front();
        got++;
        checks++;
        if (res_o !== e.r || mode_o !== e.m || width_o !== e.w) begin
          errors++;
          $display("FAIL mixed_beat%0d res=%h mode=%b required %h/%b", got, res_o, mode_o, e.r, e.m);
        end
      end
      if (valid_i && ready_o) begin
        q.push_back('{r: model(p, s, m, w), m: m, w: w});
        sent++;
      end
    end
    valid_i = 1'b0;
    checks++;
    if (got != 8) begin
      errors++;
      $display("FAIL mixed_count outputs=%0d required 8", got);
    end
  endtask

  task automatic test_backpressure();
    int unsigned acc = 0;
    logic [W-1:0] p [6];
    logic [W-1:0] s [6];
    logic [W-1:0] snap;
    logic stable;
    exp_t e;
    q.delete();
    for (int i = 0; i < 6; i++) begin p[i] = rand_word(); s[i] = rand_word(); end
    @(negedge clk);
    ready_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c != 0) @(negedge clk);
      valid_i = 1'b1;
      ps_i = p[acc]; sc_i = s[acc]; mode_i = 3'b100; width_i = 3'b001;
      #1;
      if (ready_o) begin
        q.push_back('{r: model(p[acc], s[acc], 3'b100, 3'b001), m: 3'b100, w: 3'b001});
        acc++;
      end
    end
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    checks++;
    if (acc != 4 || ready_o !== 1'b0 || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_capacity accepted=%0d ready_o=%b valid_o=%b required 4/0/1", acc, ready_o, valid_o);
    end
    snap = res_o;
    stable = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1 if (res_o !== snap || valid_o !== 1'b1) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL bp_stable res_o=%h required %h held", res_o, snap);
    end
    ready_i = 1'b1;
    for (int n = 0; n < 4; n++) begin
      if (n != 0) @(negedge clk);
      #1;
      e = q.pop_front();
      checks++;
      if (valid_o !== 1'b1 || res_o !== e.r) begin
        errors++;
        $display("FAIL bp_drain%0d valid_o=%b res=%h required 1/%h", n, valid_o, res_o, e.r);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty valid_o=%b required 0", valid_o);
    end
  endtask

  task automatic test_reset_midflight();
    logic acc; int unsigned lat; logic [W-1:0] r, p, s; logic [2:0] mo, wo;
    logic seen;
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      valid_i = 1'b1;
      ps_i = rand_word() | 256'd1; sc_i = rand_word(); mode_i = 3'b010; width_i = 3'b111;
    end
    @(negedge clk);
    valid_i = 1'b0;
    ready_i = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (valid_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre valid_o=%b required 1", valid_o);
    end
    rst_n_i = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || res_o !== '0 || mode_o !== 3'b0) begin
      errors++;
      $display("FAIL rst_async valid_o=%b res=%h required 0/0", valid_o, res_o);
    end
    @(negedge clk);
    rst_n_i = 1'b1;
    ready_i = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (valid_o) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_stale valid_o seen=%b required 0", seen);
    end
    p = rand_word(); s = rand_word();
    run_beat(p, s, 3'b100, 3'b001, acc, lat, r, mo, wo);
    checks++;
    if (r !== model(p, s, 3'b100, 3'b001) || lat != 4) begin
      errors++;
      $display("FAIL rst_post res=%h latency=%0d required %h/4", r, lat, model(p, s, 3'b100, 3'b001));
    end
  endtask

  task automatic test_random();
    int unsigned vp, rp, outs = 0, drain = 0;
    logic [W-1:0] p, s;
    logic [2:0] m, w;
    exp_t e;
    q.delete();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c % 500 == 0) begin
        vp = $urandom_range(100, 20);
        rp = $urandom_range(100, 20);
      end
      p = rand_word();
      s = rand_word();
      if ($urandom_range(3) == 0) s = ~p + 256'd1 + (rand_word() & 256'hF);
      if ($urandom_range(5) == 0) p = '1;
      case ($urandom_range(2))
        0:       m = 3'b100;
        1:       m = 3'b010;
        default: m = 3'($urandom);
      endcase
      w = 3'($urandom);
      valid_i = ($urandom_range(99) < vp);
      ready_i = ($urandom_range(99) < rp);
      ps_i = p; sc_i = s; mode_i = m; width_i = w;
      #1;
      if (valid_o && ready_i) begin
        outs++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_spurious beat=%0d res=%h required no output", outs, res_o);
        end else begin
          e = q.pop_front();
          if (res_o !== e.r || mode_o !== e.m || width_o !== e.w) begin
            errors++;
            $display("FAIL rand_beat%0d res=%h mode=%b width=%b required %h/%b/%b",
                     outs, res_o, mode_o, width_o, e.r, e.m, e.w);
          end
        end
      end
      if (valid_i && ready_o) q.push_back('{r: model(p, s, m, w), m: m, w: w});
    end
    @(negedge clk);
    valid_i = 1'b0;
    ready_i = 1'b1;
    while (q.size() != 0 && drain < 50) begin
      #1;
      if (valid_o) begin
        e = q.pop_front();
        checks++;
        if (res_o !== e.r || mode_o !== e.m || width_o !== e.w) begin
          errors++;
          $display("FAIL rand_drain res=%h required %h", res_o, e.r);
        end
      end
      @(negedge clk);
      drain++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL rand_lost pending=%0d required 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_arith_w32();
    test_arith_w256();
    test_arith_w128();
    test_boolean();
    test_mixed();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
